// File: rtl/a1_ptr_step.sv
// A1 pixel pointer (16.16 per axis) with a two-phase fraction/integer step adder.
// Latency: step_req -> step_done is 3 cycles; register writes are visible 1 edge later.
// Backpressure: step_req is ignored while busy; define A1_CLIP_EN to build the window clip flag.
module a1_ptr_step (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        step_req,
  input  logic [15:0] adda_x,
  input  logic [15:0] adda_y,
  input  logic [15:0] addf_x,
  input  logic [15:0] addf_y,
  input  logic        suba_x,
  input  logic        suba_y,
  input  logic [3:0]  ld_sel,
  input  logic [15:0] ld_data,
  input  logic [14:0] win_w,
  input  logic [14:0] win_h,
  output logic [15:0] a1_x,
  output logic [15:0] a1_y,
  output logic [15:0] a1_fx,
  output logic [15:0] a1_fy,
  output logic        step_busy,
  output logic        step_done,
  output logic        a1_clip
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FRAC = 2'd1,
    S_INT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operands; the requester need not hold its inputs past the accept edge.
  logic [15:0] op_ax_q, op_ay_q, op_fx_q, op_fy_q;
  logic        op_sx_q, op_sy_q;
  logic        capture;

  // Fraction carry-out per axis; in subtract mode a 1 means "no borrow".
  logic        cy_x_q, cy_y_q, cy_x_d, cy_y_d;

  logic [15:0] x_q, y_q, fx_q, fy_q;
  logic [15:0] x_d, y_d, fx_d, fy_d;
  logic        done_q, done_d;

  // Subtraction is done as add of the inverted operand; the +1 enters on the fraction
  // only, and the integer half picks it up through the carry.
  logic [16:0] fsum_x, fsum_y;
  logic [15:0] isum_x, isum_y;

  assign fsum_x = {1'b0, fx_q} + {1'b0, (op_sx_q ? ~op_fx_q : op_fx_q)} + 17'(op_sx_q);
  assign fsum_y = {1'b0, fy_q} + {1'b0, (op_sy_q ? ~op_fy_q : op_fy_q)} + 17'(op_sy_q);
  assign isum_x = x_q + (op_sx_q ? ~op_ax_q : op_ax_q) + {15'd0, cy_x_q};
  assign isum_y = y_q + (op_sy_q ? ~op_ay_q : op_ay_q) + {15'd0, cy_y_q};

  // Next-state and datapath update; register writes are applied last so they win.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done_d  = 1'b0;
    cy_x_d  = cy_x_q;
    cy_y_d  = cy_y_q;
    x_d     = x_q;
    y_d     = y_q;
    fx_d    = fx_q;
    fy_d    = fy_q;

    case (state_q)
      S_IDLE: begin
        if (step_req) begin
          capture = 1'b1;
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        fx_d    = fsum_x[15:0];
        fy_d    = fsum_y[15:0];
        cy_x_d  = fsum_x[16];
        cy_y_d  = fsum_y[16];
        state_d = S_INT;
      end
      S_INT: begin
        x_d     = isum_x;
        y_d     = isum_y;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_sel[0]) x_d  = ld_data;
    if (ld_sel[1]) y_d  = ld_data;
    if (ld_sel[2]) fx_d = ld_data;
    if (ld_sel[3]) fy_d = ld_data;
  end

  // State, pointer, carry and done registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      fx_q    <= 16'd0;
      fy_q    <= 16'd0;
      cy_x_q  <= 1'b0;
      cy_y_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      cy_x_q  <= cy_x_d;
      cy_y_q  <= cy_y_d;
      done_q  <= done_d;
    end
  end

  // Operand capture on the accept edge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      op_ax_q <= 16'd0;
      op_ay_q <= 16'd0;
      op_fx_q <= 16'd0;
      op_fy_q <= 16'd0;
      op_sx_q <= 1'b0;
      op_sy_q <= 1'b0;
    end else if (capture) begin
      op_ax_q <= adda_x;
      op_ay_q <= adda_y;
      op_fx_q <= addf_x;
      op_fy_q <= addf_y;
      op_sx_q <= suba_x;
      op_sy_q <= suba_y;
    end
  end

  assign a1_x      = x_q;
  assign a1_y      = y_q;
  assign a1_fx     = fx_q;
  assign a1_fy     = fy_q;
  assign step_busy = (state_q != S_IDLE);
  assign step_done = done_q;

`ifdef A1_CLIP_EN
  logic clip_q, clip_d;

  // Negative coordinates, or at/after the window edge, are outside.
  assign clip_d = x_q[15] | y_q[15] | (x_q[14:0] >= win_w) | (y_q[14:0] >= win_h);

  // Clip flag is registered, so it trails the pointer by one cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) clip_q <= 1'b0;
    else       clip_q <= clip_d;
  end

  assign a1_clip = clip_q;
`else
  logic unused_win;
  assign unused_win = ^{win_w, win_h};
  assign a1_clip    = 1'b0;
`endif

endmodule
